// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - byte-bus router to ram with an MMIO console FIFO and a halt register (optional cycle counter: MMIO_CYCLE_CNT_EN)
module mmio_bridge #(
  parameter int                 MADDR_L  = 32,
  parameter int                 M_DATA_L = 8,
  parameter logic [MADDR_L-1:0] IO_BASE  = 32'h00030000,
  parameter int                 FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [M_DATA_L-1:0] m_din,
  input  logic [MADDR_L-1:0]  m_waddr,
  input  logic                m_we,
  input  logic [MADDR_L-1:0]  m_raddr,
  input  logic                m_re,
  output logic [M_DATA_L-1:0] m_dout,
  output logic [M_DATA_L-1:0] r_din,
  output logic [MADDR_L-1:0]  r_waddr,
  output logic                r_we,
  output logic [MADDR_L-1:0]  r_raddr,
  output logic                r_re,
  input  logic [M_DATA_L-1:0] r_dout,
  output logic [M_DATA_L-1:0] io_data,
  output logic                io_valid,
  input  logic                io_ready,
  output logic                halt,
  output logic [M_DATA_L-1:0] exit_code
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic                whit, rhit;
  logic [3:0]          woff, roff;
  logic [M_DATA_L-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]  rd_ptr, wr_ptr;
  logic [FIFO_AW:0]    count;
  logic                overflow, full, empty;
  logic                push_req, push_ok, pop, halt_wr;
  logic                sel_q;
  logic [M_DATA_L-1:0] rdata_q, rd_byte;

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cyc_cnt, cyc_shadow;
`endif

  assign whit = (m_waddr[MADDR_L-1:4] == IO_BASE[MADDR_L-1:4]);
  assign rhit = (m_raddr[MADDR_L-1:4] == IO_BASE[MADDR_L-1:4]);
  assign woff = m_waddr[3:0];
  assign roff = m_raddr[3:0];

  assign r_din   = m_din;
  assign r_waddr = m_waddr;
  assign r_we    = m_we & ~whit;
  assign r_raddr = m_raddr;
  assign r_re    = m_re & ~rhit;
  assign m_dout  = sel_q ? rdata_q : r_dout;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign io_valid = ~empty;
  assign io_data  = mem[rd_ptr];

  // A full FIFO still takes a byte when the consumer frees a slot on the same edge.
  assign pop      = io_valid & io_ready;
  assign push_req = m_we & whit & (woff == 4'h0) & ~halt;
  assign push_ok  = push_req & (~full | pop);
  assign halt_wr  = m_we & whit & (woff == 4'h4) & ~halt;

  always_comb begin
    rd_byte = '0;
    case (roff)
      4'h0:    rd_byte = {{(M_DATA_L-3){1'b0}}, overflow, empty, full};
      4'h1:    rd_byte = {{(M_DATA_L-FIFO_AW-1){1'b0}}, count};
`ifdef MMIO_CYCLE_CNT_EN
      4'h8:    rd_byte = cyc_cnt[7:0];
      4'h9:    rd_byte = cyc_shadow[15:8];
      4'hA:    rd_byte = cyc_shadow[23:16];
      4'hB:    rd_byte = cyc_shadow[31:24];
`endif
      default: rd_byte = '0;
    endcase
  end

  // Storage is deliberately left out of reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= m_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      halt      <= 1'b0;
      exit_code <= '0;
      sel_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sel_q <= m_re & rhit;
      if (m_re & rhit) rdata_q <= rd_byte;
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (push_req & ~push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      if (halt_wr) begin
        halt      <= 1'b1;
        exit_code <= m_din;
      end
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  // Reading the low byte freezes the whole count so the upper bytes stay coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (m_re & rhit & (roff == 4'h8)) cyc_shadow <= cyc_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge: vector table, directed corner sequences, random vs reference model
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  m_din, m_dout, r_din, r_dout, io_data, exit_code;
  logic [31:0] m_waddr, m_raddr, r_waddr, r_raddr;
  logic        m_we, m_re, r_we, r_re, io_valid, io_ready, halt;

  always #5 clk = ~clk;

  mmio_bridge dut (
    .clk(clk), .rst(rst),
    .m_din(m_din), .m_waddr(m_waddr), .m_we(m_we),
    .m_raddr(m_raddr), .m_re(m_re), .m_dout(m_dout),
    .r_din(r_din), .r_waddr(r_waddr), .r_we(r_we),
    .r_raddr(r_raddr), .r_re(r_re), .r_dout(r_dout),
    .io_data(io_data), .io_valid(io_valid), .io_ready(io_ready),
    .halt(halt), .exit_code(exit_code)
  );

  // Bench RAM: 256 bytes aliased on the low address byte, cleared with rst.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      r_dout <= 8'h00;
    end else begin
      if (r_we) ram[r_waddr[7:0]] <= r_din;
      if (r_re) r_dout <= ram[r_raddr[7:0]];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, RAM as an array, registers as plain variables.
  logic [7:0]  q[$];
  logic        m_ovf, m_halt, prev_re;
  logic [7:0]  m_exit, prev_exp, last_dout;
  logic [7:0]  m_ram [256];
  logic [31:0] m_cyc, m_shadow;

  function automatic logic [7:0] model_read(input logic [3:0] off);
    logic [7:0] v;
    v = 8'h00;
    case (off)
      4'h0: v = {5'b0, m_ovf, q.size() == 0, q.size() == 16};
      4'h1: v = 8'(q.size());
`ifdef MMIO_CYCLE_CNT_EN
      4'h8: v = m_cyc[7:0];
      4'h9: v = m_shadow[15:8];
      4'hA: v = m_shadow[23:16];
      4'hB: v = m_shadow[31:24];
`endif
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; m_we = 1'b0; m_re = 1'b0; m_din = 8'h00;
    m_waddr = 32'h0; m_raddr = 32'h0; io_ready = 1'b0;
    @(negedge clk);
    q.delete();
    m_ovf = 1'b0; m_halt = 1'b0; m_exit = 8'h00; prev_re = 1'b0;
    m_cyc = 32'h0; m_shadow = 32'h0;
    for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
  endtask

  task automatic step(input logic we, input logic [31:0] wa, input logic [7:0] d,
                      input logic re, input logic [31:0] ra, input logic rdy);
    logic wh, rh, pop, preq;
    int   sz;
    @(posedge clk); #1;
    rst = 1'b0; m_we = we; m_waddr = wa; m_din = d; m_re = re; m_raddr = ra; io_ready = rdy;
    @(negedge clk);
    wh = (wa[31:4] == 28'h0003000);
    rh = (ra[31:4] == 28'h0003000);
    chk("r_we", 32'(r_we), 32'(we & ~wh));
    chk("r_re", 32'(r_re), 32'(re & ~rh));
    chk("fwd_waddr_din", {r_waddr[23:0], r_din}, {wa[23:0], d});
    chk("fwd_raddr", r_raddr, ra);
    chk("io_valid", 32'(io_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("io_data", 32'(io_data), 32'(q[0]));
    chk("halt", 32'(halt), 32'(m_halt));
    chk("exit_code", 32'(exit_code), 32'(m_exit));
    if (prev_re) chk("m_dout", 32'(m_dout), 32'(prev_exp));
    last_dout = m_dout;
    prev_re  = re;
    prev_exp = rh ? model_read(ra[3:0]) : m_ram[ra[7:0]];
    if (re && rh && ra[3:0] == 4'h8) m_shadow = m_cyc;
    sz   = q.size();
    pop  = (sz != 0) && rdy;
    preq = we && wh && (wa[3:0] == 4'h0) && !m_halt;
    if (pop) void'(q.pop_front());
    if (preq) begin
      if (sz < 16 || pop) q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (we && wh && wa[3:0] == 4'h4 && !m_halt) begin
      m_halt = 1'b1;
      m_exit = d;
    end
    if (we && !wh) m_ram[wa[7:0]] = d;
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic rdy);
    step(1'b1, a, d, 1'b0, 32'h0, rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy, output logic [7:0] v);
    step(1'b0, 32'h0, 8'h00, 1'b1, a, rdy);
    step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, rdy);
    v = last_dout;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 19);
    if (k < 8)   return {23'h0, 9'($urandom_range(0, 511))};
    if (k == 8)  return 32'h00030010;
    if (k == 9)  return 32'h0002FFFF;
    if (k == 10) return 32'h00030004;
    if (k < 14)  return 32'h00030000;
    return 32'h00030000 + 32'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [7:0]  d;
    logic        re;
    logic [31:0] ra;
    logic        rdy;
    logic        e_rwe;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_dchk;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] v, b0, b1, b2, b3;
  logic [31:0] snap;

  initial begin
    tbl[0] = '{1'b1, 32'h00000100, 8'h5A, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 32'h0,        8'h00, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 32'h0,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A};
    tbl[3] = '{1'b1, 32'h00030000, 8'h48, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 32'h0,        8'h00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h48, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 32'h0,        8'h00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

    rst = 1'b1; m_we = 1'b0; m_re = 1'b0; m_din = 8'h00;
    m_waddr = 32'h0; m_raddr = 32'h0; io_ready = 1'b0;
    #100;
    do_reset();
    step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
    chk("reset_io_valid", 32'(io_valid), 32'h0);
    chk("reset_halt", 32'(halt), 32'h0);
    chk("reset_exit", 32'(exit_code), 32'h0);

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].re, tbl[i].ra, tbl[i].rdy);
      chk("tbl_r_we", 32'(r_we), 32'(tbl[i].e_rwe));
      chk("tbl_io_valid", 32'(io_valid), 32'(tbl[i].e_valid));
      chk("tbl_halt", 32'(halt), 32'h0);
      if (tbl[i].e_valid) chk("tbl_io_data", 32'(io_data), 32'(tbl[i].e_data));
      if (tbl[i].e_dchk) chk("tbl_m_dout", 32'(last_dout), 32'(tbl[i].e_dout));
    end

    // 17 pushes into a stalled FIFO: the 17th is dropped and flags overflow.
    do_reset();
    for (int i = 0; i <= 16; i++) wr(32'h00030000, 8'(i), 1'b0);
    rd(32'h00030000, 1'b0, v);
    chk("status_full_ovf", 32'(v), 32'h05);
    rd(32'h00030001, 1'b0, v);
    chk("count_16", 32'(v), 32'h10);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b1);
      chk("drain_order", 32'(io_data), 32'(i));
    end
    step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b1);
    chk("drain_empty", 32'(io_valid), 32'h0);

    // Full FIFO with a concurrent pop still accepts the push.
    do_reset();
    for (int i = 0; i < 16; i++) wr(32'h00030000, 8'(8'h20 + i), 1'b0);
    wr(32'h00030000, 8'hAA, 1'b1);
    rd(32'h00030000, 1'b0, v);
    chk("status_full_no_ovf", 32'(v), 32'h01);
    rd(32'h00030001, 1'b0, v);
    chk("count_still_16", 32'(v), 32'h10);
    chk("head_after_pop", 32'(io_data), 32'h21);

    // Halt is sticky: later exit writes and pushes are ignored.
    do_reset();
    wr(32'h00030004, 8'h07, 1'b0);
    chk("halt_not_yet", 32'(halt), 32'h0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
    chk("halt_set", 32'(halt), 32'h1);
    chk("exit_first", 32'(exit_code), 32'h07);
    wr(32'h00030004, 8'h09, 1'b0);
    wr(32'h00030000, 8'h41, 1'b0);
    rd(32'h00030001, 1'b0, v);
    chk("halt_blocks_push", 32'(v), 32'h00);
    chk("exit_held", 32'(exit_code), 32'h07);

    // Reset in the middle of draining a loaded FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) wr(32'h00030000, 8'(8'h60 + i), 1'b0);
    wr(32'h00030004, 8'h33, 1'b1);
    do_reset();
    step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b1);
    chk("rst_io_valid", 32'(io_valid), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_exit", 32'(exit_code), 32'h0);
    chk("rst_dout_pass", 32'(m_dout), 32'(r_dout));
    rd(32'h00030001, 1'b0, v);
    chk("rst_count", 32'(v), 32'h00);

`ifdef MMIO_CYCLE_CNT_EN
    repeat (3) step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
    snap = m_cyc;
    step(1'b0, 32'h0, 8'h00, 1'b1, 32'h00030008, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 32'h00030009, 1'b0); b0 = last_dout;
    step(1'b0, 32'h0, 8'h00, 1'b1, 32'h0003000A, 1'b0); b1 = last_dout;
    step(1'b0, 32'h0, 8'h00, 1'b1, 32'h0003000B, 1'b0); b2 = last_dout;
    step(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);        b3 = last_dout;
    chk("cyc_snapshot", {b3, b2, b1, b0}, snap);
`else
    rd(32'h00030008, 1'b0, v);
    chk("cyc_absent", 32'(v), 32'h00);
`endif

    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
